uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, parametrised UART transmitter; successor to the single-byte transmitter. It accepts words into an internal FIFO and serialises them back-to-back onto `tx`. Frames are start bit, `WIDTH` data bits LSB first, optional parity, and 1 or 2 stop bits. It sits between the CPU-side peripheral register block and the board TX pin, and shares the 16-bit `clock_divider` convention with the existing UART blocks.

## Interface
- `WIDTH`, 8: data bits per frame, 5..9.
- `DEPTH`, 4: FIFO entries, power of two, 2..64.
- `clock` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `clock_divider` in 16: bit period is `clock_divider`+1 clocks.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `two_stop` in 1: 1 selects two stop bits.
- `data_in` in WIDTH: word to enqueue.
- `write_en` in 1: enqueue request.
- `ready` out 1: FIFO not full. A write is accepted when `write_en & ready`.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `idle` out 1: FIFO empty and no frame in progress.
- `tx` out 1: serial line, idles high.

## Operation
- Shifter FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on any edge where the FIFO is non-empty. That edge pops the head, latches the word, `parity_mode`, `two_stop` and `clock_divider`, and clears the bit counter.
- Each state holds `tx` for one bit period, i.e. `clock_divider`+1 clocks counted 0..divider.
- START drives 0.
- DATA drives bits 0..WIDTH-1, one per period.
- PARITY drives parity, and is entered only if the latched mode is 01 or 10:
  - even: XOR of the data bits;
  - odd: the inverse of that XOR.
- STOP drives 1 for one period, or two periods if latched `two_stop`=1.
- At the end of STOP:
  - FIFO non-empty: pop and go to START on the same edge, giving back-to-back frames with no idle gap;
  - FIFO empty: go to IDLE.
- Configuration inputs changed mid-frame do not affect the current frame; they take effect at the next load.
- FIFO behaviour:
  - write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap modulo DEPTH;
  - `level` is a separate counter.
- Simultaneous push and pop: `level` unchanged and both pointers advance.
- Full: `ready`=0 and `write_en` is ignored, even if a pop occurs on that edge. There is no full-bypass.
- Empty: no pop, and the FSM stays in IDLE with `tx`=1.
- `clock_divider`=0 is legal and gives 1 clock per bit.

## Timing
- Reset values:
  - `tx`=1, `ready`=1, `idle`=1, `level`=0;
  - FSM in IDLE, pointers and counters 0, FIFO contents don't-care.
- Reset asserted mid-frame aborts the frame. `tx`=1 from the first edge with `reset` high, and the FIFO is emptied.
- All outputs are registered.
- Latency from an accepted write into an empty, idle block:
  - edge N: write accepted, `level`=1;
  - edge N+1: pop, `level`=0, `tx` goes 0;
  - `idle` is 0 from edge N onward.
- Frame length in clocks is (`clock_divider`+1) × (1 + WIDTH + P + S), where P is 0 or 1 and S is 1 or 2.
- `idle` rises on the edge that ends the last STOP period with the FIFO empty. `tx` is 1 at that point.
- `ready` falls on the edge where `level` reaches DEPTH. It rises on the edge after which `level` is DEPTH-1.

## Configuration
- `UART_TX_PARITY_EN`:
  - defined: `parity_mode` is honoured and the PARITY state and parity XOR are present;
  - undefined: `parity_mode` is ignored, there is no PARITY state, and frames are always start/data/stop.

## Structure
- Shared package `uart_pkg`:
  - parity mode encodings `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`;
  - FSM state typedef `uart_tx_state_t`;
  - divider width constant `UART_DIV_W` = 16.
- Sub-module `uart_sync_fifo`: parameters WIDTH and DEPTH; ports push, pop, full, empty, level. It will be reused by the planned RX block.
- Top level holds the FSM, the bit-period counter and the parity logic.

## Test plan
- Reset, then `clock_divider`=3, no parity, one stop, write 0xA5. Required response: `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, starting 1 edge after the write. `idle` returns to 1 after 40 clocks.
- Write 0x01, 0x02, 0x03 on consecutive cycles with divider 0. Required response: three frames back-to-back, with no clock of `tx`=1 between the stop bit and the next start bit.
- DEPTH=4, divider 100, write 6 words on consecutive cycles. Required response: `ready` drops once 4 entries are buffered and the 6th write is dropped. Exactly 5 frames are transmitted (1 in flight + 4 buffered).
- With `UART_TX_PARITY_EN` defined, 0x07 in even mode, then in odd mode. Required response: the parity bit is 1 in even mode and 0 in odd mode, placed after bit 7.
- `two_stop`=1, divider 1, write 0xFF. Required response: stop high for 4 clocks, and the total frame is 22 clocks.
- Assert `reset` during DATA bit 3 with 2 words queued. Required response: `tx`=1 on the next edge, `level`=0, `idle`=1, and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, shifter state type, divider width.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY shifter state.
package uart_pkg;

  localparam int UART_DIV_W = 16;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

  // Parity over up to 9 data bits; narrower words are zero-extended by the caller.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle of the buffered UART transmitter.
// Optional feature macro of the block: UART_TX_PARITY_EN (no effect here).
interface uart_tx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         data_in;
  logic                     write_en;
  logic                     ready;
  logic [$clog2(DEPTH):0]   level;

  modport master (output data_in, output write_en, input ready, input level);
  modport slave  (input data_in, input write_en, output ready, output level);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; shared by UART TX and RX.
// Writes while full are dropped even if a pop happens on the same edge.
// Optional feature macro of the block: UART_TX_PARITY_EN (no effect here).
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer, level and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LW'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Head word is visible in the same cycle it becomes valid so the consumer
  // can latch it on the popping edge.
  assign pop_data = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end plus a start/data/parity/stop shifter.
// Optional feature macro: UART_TX_PARITY_EN enables the parity bit and PARITY state;
// without it parity_mode is ignored and frames are start/data/stop only.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [UART_DIV_W-1:0] clock_divider,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  uart_tx_fifo_if.slave         wr,
  output logic                  idle,
  output logic                  tx
);
  localparam int BW = $clog2(WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [UART_DIV_W-1:0] DIV_ONE = 1;

  uart_tx_state_t        state_q;
  logic                  tx_q;
  logic                  idle_q, idle_d;
  logic                  two_stop_q;
  logic                  stop_cnt_q;
  logic [UART_DIV_W-1:0] div_q;
  logic [UART_DIV_W-1:0] div_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [WIDTH-1:0]      shift_q;

  logic                  fifo_full, fifo_empty;
  logic [LW-1:0]         fifo_level;
  logic [WIDTH-1:0]      head_word;
  logic                  period_end, stop_last, pop;

`ifdef UART_TX_PARITY_EN
  logic                  par_en_q;
  logic                  par_bit_q;
`else
  logic                  cfg_unused;
  assign cfg_unused = ^parity_mode;
`endif

  uart_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr.write_en),
    .push_data (wr.data_in),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign wr.ready = ~fifo_full;
  assign wr.level = fifo_level;

  // Bit-period end, last stop period, and the pop that starts the next frame.
  always_comb begin
    period_end = (div_cnt_q == div_q);
    stop_last  = period_end && (!two_stop_q || stop_cnt_q);
    pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && stop_last));
    // Idle next cycle: shifter heading to IDLE with nothing queued or arriving.
    idle_d     = fifo_empty && !wr.write_en &&
                 ((state_q == IDLE) || ((state_q == STOP) && stop_last));
  end

  // Shifter FSM with registered tx/idle; config is latched only when a word is loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      idle_q     <= 1'b1;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      idle_q    <= idle_d;
      div_cnt_q <= period_end ? '0 : div_cnt_q + DIV_ONE;
      if (pop) begin
        state_q    <= START;
        tx_q       <= 1'b0;
        shift_q    <= head_word;
        div_q      <= clock_divider;
        div_cnt_q  <= '0;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        two_stop_q <= two_stop;
`ifdef UART_TX_PARITY_EN
        par_en_q   <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
        par_bit_q  <= calc_parity(9'(head_word), parity_mode == PARITY_ODD);
`endif
      end else begin
        case (state_q)
          IDLE: begin
            tx_q      <= 1'b1;
            div_cnt_q <= '0;
          end
          START: begin
            if (period_end) begin
              state_q   <= DATA;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            if (period_end) begin
              if (bit_cnt_q == BW'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                if (par_en_q) begin
                  state_q <= PARITY;
                  tx_q    <= par_bit_q;
                end else
`endif
                begin
                  state_q    <= STOP;
                  tx_q       <= 1'b1;
                  stop_cnt_q <= 1'b0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
                tx_q      <= shift_q[0];
                shift_q   <= shift_q >> 1;
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (period_end) begin
              state_q    <= STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
            end
          end
`endif
          STOP: begin
            if (period_end) begin
              if (stop_last) begin
                // pop is low here, so the FIFO is empty: go quiet.
                state_q <= IDLE;
                tx_q    <= 1'b1;
              end else begin
                stop_cnt_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign idle = idle_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes expected frames, a serial
// monitor decodes tx and compares. Honors UART_TX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clock_divider = 16'd0;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        idle, tx;

  uart_tx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) wr_if ();

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .clock_divider (clock_divider),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .wr            (wr_if),
    .idle          (idle),
    .tx            (tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               par_en;
    bit               odd;
    bit               two;
    int               div;
  } frame_t;

  frame_t exp_q[$];
  int     start_q[$];
  int     checks = 0;
  int     passes = 0;
  int     cyc = 0;
  int     frames_started = 0;
  int     frames_done = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  function automatic void push_exp(input logic [WIDTH-1:0] d, input bit p,
                                   input bit o, input bit t, input int dv);
    frame_t f;
    f.data = d; f.par_en = p; f.odd = o; f.two = t; f.div = dv;
    exp_q.push_back(f);
  endfunction

  // Serial monitor: decodes frames on tx using the format of the expected frame.
  frame_t      cur;
  bit          in_frame = 1'b0;
  bit          bogus, hold_bad;
  int          bit_i, ck, nbits;
  logic [12:0] got_bits, exp_bits;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (in_frame) begin
          in_frame = 1'b0;
          exp_q.delete();
        end
      end else begin
        if (!in_frame && tx == 1'b0) begin
          frames_started++;
          start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("frame_expected", 0, 1);
            bogus = 1'b1;
            cur.data = '0; cur.par_en = 1'b0; cur.odd = 1'b0; cur.two = 1'b0; cur.div = 0;
          end else begin
            bogus = 1'b0;
            cur = exp_q.pop_front();
          end
          in_frame = 1'b1;
          bit_i = 0; ck = 0; hold_bad = 1'b0; got_bits = '1;
          nbits = 1 + WIDTH + (cur.par_en ? 1 : 0) + (cur.two ? 2 : 1);
        end
        if (in_frame) begin
          if (ck == 0) got_bits[bit_i] = tx;
          else if (tx !== got_bits[bit_i]) hold_bad = 1'b1;
          ck++;
          if (ck == cur.div + 1) begin
            ck = 0;
            bit_i++;
            if (bit_i == nbits) begin
              in_frame = 1'b0;
              frames_done++;
              exp_bits = '1;
              exp_bits[0] = 1'b0;
              for (int i = 0; i < WIDTH; i++) exp_bits[1 + i] = cur.data[i];
              if (cur.par_en) exp_bits[1 + WIDTH] = (^cur.data) ^ cur.odd;
              if (!bogus) begin
                $display("frame data=0x%02h bits=%b hold_ok=%0d", cur.data, got_bits, !hold_bad);
                check("frame_bits", {hold_bad, got_bits}, {1'b0, exp_bits});
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_if.data_in  = d;
    wr_if.write_en = 1'b1;
    tick();
    wr_if.write_en = 1'b0;
    $display("write 0x%02h level=%0d ready=%0d", d, wr_if.level, wr_if.ready);
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (!idle && n < max) begin
      tick();
      n++;
    end
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  int n, f0, s0;

  initial begin
    wr_if.data_in  = '0;
    wr_if.write_en = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_ready", wr_if.ready, 1);
    check("rst_idle", idle, 1);
    check("rst_level", wr_if.level, 0);
    reset = 1'b0;
    tick();

    // Single frame 0xA5, divider 3; divider changed mid-frame must not matter
    clock_divider = 16'd3;
    push_exp(8'hA5, 0, 0, 0, 3);
    write_word(8'hA5);
    check("lat_level_n", wr_if.level, 1);
    check("lat_idle_n", idle, 0);
    check("lat_tx_n", tx, 1);
    tick();
    check("lat_tx_n1", tx, 0);
    check("lat_level_n1", wr_if.level, 0);
    clock_divider = 16'd7;
    repeat (39) tick();
    check("idle_before_end", idle, 0);
    tick();
    check("idle_at_end", idle, 1);
    check("tx_at_end", tx, 1);
    $display("test1 done");

    // Back-to-back frames at divider 0
    clock_divider = 16'd0;
    start_q.delete();
    push_exp(8'h01, 0, 0, 0, 0);
    push_exp(8'h02, 0, 0, 0, 0);
    push_exp(8'h03, 0, 0, 0, 0);
    wr_if.write_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_if.data_in = WIDTH'(i);
      tick();
    end
    wr_if.write_en = 1'b0;
    wait_idle(100, n);
    check("b2b_idle_cycles", n, 29);
    check("b2b_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("b2b_gap01", start_q[1] - start_q[0], 10);
      check("b2b_gap12", start_q[2] - start_q[1], 10);
    end

    // Overflow: 6 writes into DEPTH 4 while first frame is in flight
    clock_divider = 16'd100;
    f0 = frames_done;
    for (int i = 0; i < 5; i++) push_exp(WIDTH'(8'h10 + i), 0, 0, 0, 100);
    wr_if.write_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_if.data_in = WIDTH'(8'h10 + i);
      tick();
      $display("burst write %0d level=%0d ready=%0d", i, wr_if.level, wr_if.ready);
      if (i == 3) check("ovf_ready_l3", wr_if.ready, 1);
      if (i >= 4) begin
        check("ovf_ready_full", wr_if.ready, 0);
        check("ovf_level_full", wr_if.level, DEPTH);
      end
    end
    wr_if.write_en = 1'b0;
    n = 0;
    while (wr_if.level == DEPTH && n < 3000) begin
      tick();
      n++;
    end
    check("ovf_level_drop", wr_if.level, DEPTH - 1);
    check("ovf_ready_rise", wr_if.ready, 1);
    wait_idle(7000, n);
    check("ovf_frames", frames_done - f0, 5);

    // Parity (or its absence in the default build), divider 1
    clock_divider = 16'd1;
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b01;
    push_exp(8'h07, 1, 0, 0, 1);
    write_word(8'h07);
    wait_idle(100, n);
    check("par_even_len", n, 23);
    parity_mode = 2'b10;
    push_exp(8'h07, 1, 1, 0, 1);
    write_word(8'h07);
    wait_idle(100, n);
    check("par_odd_len", n, 23);
`else
    parity_mode = 2'b01;
    push_exp(8'h07, 0, 0, 0, 1);
    write_word(8'h07);
    wait_idle(100, n);
    check("nopar_len", n, 21);
`endif
    parity_mode = 2'b00;

    // Two stop bits, divider 1: 22-clock frame
    two_stop = 1'b1;
    push_exp(8'hFF, 0, 0, 1, 1);
    write_word(8'hFF);
    wait_idle(100, n);
    check("two_stop_len", n, 23);
    two_stop = 1'b0;

    // Reset during data bit 3 with two words still queued
    clock_divider = 16'd3;
    push_exp(8'h77, 0, 0, 0, 3);
    push_exp(8'h5A, 0, 0, 0, 3);
    push_exp(8'h3C, 0, 0, 0, 3);
    wr_if.write_en = 1'b1;
    wr_if.data_in = 8'h77; tick();
    wr_if.data_in = 8'h5A; tick();
    wr_if.data_in = 8'h3C; tick();
    wr_if.write_en = 1'b0;
    repeat (15) tick();
    check("rst_mid_bit3", tx, 0);
    check("rst_mid_level", wr_if.level, 2);
    s0 = frames_started;
    reset = 1'b1;
    tick();
    check("rst_mid_tx", tx, 1);
    check("rst_mid_level0", wr_if.level, 0);
    check("rst_mid_idle", idle, 1);
    reset = 1'b0;
    repeat (200) tick();
    check("rst_no_frames", frames_started - s0, 0);
    check("rst_tx_quiet", tx, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
